branch_unit: RTL and testbench
==============================

Name: branch_unit

Overview:
- Program-counter and conditional-transfer stage directly downstream of the comparator.
- Consumes the comparator's registered flags word and evaluates a 3-bit condition code against it.
- Updates the PC for sequential step, jump, call and return.
- Holds a small return-address stack and drives a one-cycle flush to the fetch side on every taken transfer.

Parameters:
- WIDTH, 16, PC / target / bus width.
- STACK_DEPTH, 4, return-address stack entries (power of 2, >=2).
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- step  in  1  advance PC by 1.
- branch  in  1  conditional jump request.
- call  in  1  conditional call request.
- ret  in  1  conditional return request.
- cond  in  3  condition select: 0 ALWAYS, 1 EQ, 2 NE, 3 LT, 4 GT, 5 LE, 6 GE, 7 NEVER.
- target  in  WIDTH  jump/call destination.
- flags  in  16  comparator flags: [0] EQ, [1] NE, [2] LT (bus1<bus2), [3] GT (bus1>bus2), [15:4] ignored.
- pc  out  WIDTH  current program counter.
- taken  out  1  one-cycle pulse: last request transferred control.
- flush  out  1  one-cycle pulse: discard fetched instruction.
- stack_full  out  1  return stack holds STACK_DEPTH entries.
- stack_empty  out  1  return stack holds 0 entries.
- fault  out  1  sticky: call on full or ret on empty.

Behaviour:
- Reset, synchronous and active-high, wins over everything:
  - pc=RESET_PC, taken=0, flush=0, fault=0.
  - Stack count=0, so stack_empty=1 and stack_full=0.
  - State=RUN.
  - Reset asserted mid-FLUSH aborts it.
- Condition evaluation is combinational on flags at the request edge:
  - LE = EQ|LT, GE = EQ|GT.
  - ALWAYS=1, NEVER=0.
  - Flags arrive registered from the comparator, so no extra sampling register.
- Request priority when several are high: ret > call > branch > step. Only one is acted on per cycle.
- FSM has 2 states, RUN and FLUSH.
- In RUN, at each edge:
  - branch, cond true: pc<=target, taken<=1, flush<=1, go FLUSH.
  - branch, cond false: pc<=pc+1, no pulse.
  - call, cond true, not full: push pc+1, pc<=target, taken/flush pulse, go FLUSH.
  - call, cond true, full: no push, pc<=pc+1, fault<=1, no pulse.
  - ret, cond true, not empty: pop, pc<=popped value, taken/flush pulse, go FLUSH.
  - ret, cond true, empty: pc<=pc+1, fault<=1, no pulse.
  - call/ret with cond false: pc<=pc+1, stack unchanged.
  - step only: pc<=pc+1.
  - No request: pc held.
- In FLUSH:
  - All requests are ignored and pc is held.
  - taken<=0, flush<=0, go RUN.
  - FLUSH lasts exactly 1 cycle.
- Latency:
  - Transfer is visible on pc 1 cycle after the request edge; taken/flush are high in that same cycle.
  - The next request is accepted 2 edges after the transfer request.
- Arithmetic: pc+1 is modulo 2^WIDTH, so 16'hFFFF -> 16'h0000. A call at pc=16'hFFFF pushes 16'h0000.
- Stack:
  - LIFO, count 0..STACK_DEPTH.
  - stack_full and stack_empty are registered from count.
  - Push and pop never occur in the same cycle.
- fault stays set until reset. The unit keeps operating after fault.

Decomposition:
- Shared package, cpu_pkg:
  - Condition-code constants COND_ALWAYS..COND_NEVER.
  - Flag bit indices FLAG_EQ=0, FLAG_NE=1, FLAG_LT=2, FLAG_GT=3 (also used by the comparator).
  - FSM state encoding.
- One natural sub-module: return_stack (push, pop, data in/out, full, empty), parameterised by WIDTH and STACK_DEPTH.
- Condition evaluation and the FSM stay in branch_unit.

Test Plan:
- Reset, then step x3 -> pc=0,1,2,3; taken=0; stack_empty=1.
- pc=5, flags=16'h0001, branch cond=EQ target=16'h0040 -> pc=16'h0040, taken=flush=1 for 1 cycle; a step during FLUSH is ignored (pc stays 16'h0040).
- flags=16'h000A (GT), branch cond=LT target=16'h0080 from pc=16'h0010 -> pc=16'h0011, taken=0; then branch cond=GE -> pc=16'h0080.
- Call x4 cond=ALWAYS targets 16'h0100..16'h0103 -> stack_full=1; 5th call -> fault=1, pc increments; ret x4 -> pc returns through pushed addresses, stack_empty=1.
- ret on empty stack with cond=ALWAYS -> fault=1, pc+1, no taken; fault persists until reset.
- pc=16'hFFFF, step -> pc=16'h0000. Reset asserted during FLUSH -> next cycle pc=RESET_PC, flush=0, state RUN.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, comparator flag bit positions and
// the branch-unit FSM encoding.
package cpu_pkg;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_EQ     = 3'd1,
        COND_NE     = 3'd2,
        COND_LT     = 3'd3,
        COND_GT     = 3'd4,
        COND_LE     = 3'd5,
        COND_GE     = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    localparam int FLAG_EQ = 0;
    localparam int FLAG_NE = 1;
    localparam int FLAG_LT = 2;
    localparam int FLAG_GT = 3;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } bu_state_e;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses with registered full/empty flags.
// Pushes on full and pops on empty are ignored here; the caller flags them.
module return_stack #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] mem_q [STACK_DEPTH];
    logic [CW-1:0]    count_q, count_d, count_m1;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push, do_pop;
    logic [AW-1:0]    wr_idx, rd_idx;

    assign do_push  = push && !full_q;
    assign do_pop   = pop && !empty_q;
    assign count_m1 = count_q - CW'(1);
    assign wr_idx   = count_q[AW-1:0];
    assign rd_idx   = count_m1[AW-1:0];
    assign top_data = mem_q[rd_idx];
    assign full     = full_q;
    assign empty    = empty_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_m1;
        end
        full_d  = (count_d == CW'(STACK_DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // NOTE: storage has no reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// PC / conditional-transfer stage: evaluates a condition against the comparator
// flags and performs step, jump, call and return with a one-cycle flush.
module branch_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter int               STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    input  logic             branch,
    input  logic             call,
    input  logic             ret,
    input  logic [2:0]       cond,
    input  logic [WIDTH-1:0] target,
    input  logic [15:0]      flags,
    output logic [WIDTH-1:0] pc,
    output logic             taken,
    output logic             flush,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             fault
);

    bu_state_e        state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
    logic             taken_q, taken_d;
    logic             flush_q, flush_d;
    logic             fault_q, fault_d;
    logic             cond_true;
    logic             stk_push, stk_pop;
    logic [WIDTH-1:0] stk_top;
    logic             stk_full, stk_empty;
    logic             unused_flags;

    assign unused_flags = ^flags[15:4];
    assign pc_inc       = pc_q + WIDTH'(1);

    return_stack #(
        .WIDTH      (WIDTH),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (stk_push),
        .pop      (stk_pop),
        .push_data(pc_inc),
        .top_data (stk_top),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    // Flags are already registered by the comparator, so they are used directly.
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond))
            COND_ALWAYS: cond_true = 1'b1;
            COND_EQ:     cond_true = flags[FLAG_EQ];
            COND_NE:     cond_true = flags[FLAG_NE];
            COND_LT:     cond_true = flags[FLAG_LT];
            COND_GT:     cond_true = flags[FLAG_GT];
            COND_LE:     cond_true = flags[FLAG_EQ] | flags[FLAG_LT];
            COND_GE:     cond_true = flags[FLAG_EQ] | flags[FLAG_GT];
            COND_NEVER:  cond_true = 1'b0;
            default:     cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        taken_d  = 1'b0;
        flush_d  = 1'b0;
        fault_d  = fault_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        if (state_q == ST_RUN) begin
            if (ret) begin
                if (cond_true && !stk_empty) begin
                    stk_pop = 1'b1;
                    pc_d    = stk_top;
                    taken_d = 1'b1;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    pc_d    = pc_inc;
                    fault_d = fault_q | cond_true;
                end
            end else if (call) begin
                if (cond_true && !stk_full) begin
                    stk_push = 1'b1;
                    pc_d     = target;
                    taken_d  = 1'b1;
                    flush_d  = 1'b1;
                    state_d  = ST_FLUSH;
                end else begin
                    pc_d    = pc_inc;
                    fault_d = fault_q | cond_true;
                end
            end else if (branch) begin
                if (cond_true) begin
                    pc_d    = target;
                    taken_d = 1'b1;
                    flush_d = 1'b1;
                    state_d = ST_FLUSH;
                end else begin
                    pc_d = pc_inc;
                end
            end else if (step) begin
                pc_d = pc_inc;
            end
        end else begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            taken_q <= 1'b0;
            flush_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            taken_q <= taken_d;
            flush_q <= flush_d;
            fault_q <= fault_d;
        end
    end

    assign pc          = pc_q;
    assign taken       = taken_q;
    assign flush       = flush_q;
    assign fault       = fault_q;
    assign stack_full  = stk_full;
    assign stack_empty = stk_empty;

endmodule

// File: tb/tb_branch_unit.sv
// Directed test of branch_unit: stepping, conditional branches, call/return
// stack limits, faults, PC wrap-around and reset during a flush.
module tb_branch_unit;

    logic        clk;
    logic        reset;
    logic        step, branch, call, ret;
    logic [2:0]  cond;
    logic [15:0] target;
    logic [15:0] flags;
    logic [15:0] pc;
    logic        taken, flush, stack_full, stack_empty, fault;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] C_ALWAYS = 3'd0;
    localparam logic [2:0] C_EQ     = 3'd1;
    localparam logic [2:0] C_LT     = 3'd3;
    localparam logic [2:0] C_LE     = 3'd5;
    localparam logic [2:0] C_GE     = 3'd6;
    localparam logic [2:0] C_NEVER  = 3'd7;

    branch_unit #(
        .WIDTH      (16),
        .STACK_DEPTH(4),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .step       (step),
        .branch     (branch),
        .call       (call),
        .ret        (ret),
        .cond       (cond),
        .target     (target),
        .flags      (flags),
        .pc         (pc),
        .taken      (taken),
        .flush      (flush),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .fault      (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Apply one request for a single edge, then sample #1 after that edge.
    task automatic drive(input logic s, input logic b, input logic c, input logic r,
                         input logic [2:0] cd, input logic [15:0] tg);
        step = s; branch = b; call = c; ret = r; cond = cd; target = tg;
        @(posedge clk);
        #1;
        step = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, C_ALWAYS, 16'h0000);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; step = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        cond = 3'd0; target = 16'h0000; flags = 16'h0000;

        // Reset state
        do_reset();
        check("rst_pc", pc, 16'h0000);
        check("rst_taken", taken, 0);
        check("rst_flush", flush, 0);
        check("rst_empty", stack_empty, 1);
        check("rst_full", stack_full, 0);
        check("rst_fault", fault, 0);

        // Sequential stepping
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, C_ALWAYS, 16'h0000);
            check("step_pc", pc, i);
            check("step_taken", taken, 0);
        end
        check("step_empty", stack_empty, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, C_ALWAYS, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b0, C_ALWAYS, 16'h0000);
        check("pc_5", pc, 16'h0005);

        // Taken EQ branch, step during FLUSH is ignored
        flags = 16'h0001;
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_EQ, 16'h0040);
        check("beq_pc", pc, 16'h0040);
        check("beq_taken", taken, 1);
        check("beq_flush", flush, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, C_ALWAYS, 16'h0000);
        check("flush_pc", pc, 16'h0040);
        check("flush_taken", taken, 0);
        check("flush_flush", flush, 0);

        // Move to 0x0010, then LT false / GE true with GT flags
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_ALWAYS, 16'h0010);
        idle();
        check("pc_10", pc, 16'h0010);
        flags = 16'h000A;
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_LT, 16'h0080);
        check("blt_pc", pc, 16'h0011);
        check("blt_taken", taken, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_LE, 16'h0080);
        check("ble_pc", pc, 16'h0012);
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_GE, 16'h0080);
        check("bge_pc", pc, 16'h0080);
        check("bge_taken", taken, 1);
        idle();
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_NEVER, 16'h0200);
        check("bnever_pc", pc, 16'h0081);
        check("bnever_taken", taken, 0);

        // ret with false condition on empty stack: advance, no fault
        drive(1'b0, 1'b0, 1'b0, 1'b1, C_EQ, 16'h0000);
        check("retf_pc", pc, 16'h0082);
        check("retf_fault", fault, 0);

        // Fill the stack
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, C_ALWAYS, 16'h0100 + 16'(i));
            check("call_pc", pc, 16'h0100 + i);
            check("call_taken", taken, 1);
            check("call_full", stack_full, (i == 3) ? 1 : 0);
            idle();
        end
        check("full_empty", stack_empty, 0);
        check("prefault", fault, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, C_ALWAYS, 16'h0200);
        check("callfull_pc", pc, 16'h0104);
        check("callfull_fault", fault, 1);
        check("callfull_taken", taken, 0);
        check("callfull_full", stack_full, 1);

        // Unwind: 0x0103, 0x0102, 0x0101, 0x0083
        drive(1'b0, 1'b0, 1'b0, 1'b1, C_ALWAYS, 16'h0000);
        check("ret1_pc", pc, 16'h0103);
        check("ret1_taken", taken, 1);
        check("ret1_full", stack_full, 0);
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, C_ALWAYS, 16'h0000);
        check("ret2_pc", pc, 16'h0102);
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, C_ALWAYS, 16'h0000);
        check("ret3_pc", pc, 16'h0101);
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, C_ALWAYS, 16'h0000);
        check("ret4_pc", pc, 16'h0083);
        check("ret4_empty", stack_empty, 1);
        idle();

        // Reset clears fault; ret on empty sets it again and it sticks
        do_reset();
        check("rst2_fault", fault, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, C_ALWAYS, 16'h0000);
        check("retempty_pc", pc, 16'h0001);
        check("retempty_fault", fault, 1);
        check("retempty_taken", taken, 0);
        check("retempty_flush", flush, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, C_ALWAYS, 16'h0000);
        check("fault_sticky", fault, 1);
        check("fault_pc", pc, 16'h0002);

        // Wrap-around on step and on call push
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_ALWAYS, 16'hFFFF);
        idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, C_ALWAYS, 16'h0000);
        check("wrap_step", pc, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_ALWAYS, 16'hFFFF);
        idle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, C_ALWAYS, 16'h0020);
        check("wrapcall_pc", pc, 16'h0020);
        idle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, C_ALWAYS, 16'h0000);
        check("wrapret_pc", pc, 16'h0000);
        idle();

        // Priority: ret beats call and branch
        drive(1'b0, 1'b0, 1'b1, 1'b0, C_ALWAYS, 16'h0030);
        idle();
        step = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b1, C_ALWAYS, 16'h0099);
        check("prio_pc", pc, 16'h0001);
        check("prio_empty", stack_empty, 1);
        idle();

        // Reset during FLUSH aborts it; next request accepted at once
        drive(1'b0, 1'b1, 1'b0, 1'b0, C_ALWAYS, 16'h0050);
        check("pre_rst_flush", flush, 1);
        do_reset();
        check("rstflush_pc", pc, 16'h0000);
        check("rstflush_flush", flush, 0);
        check("rstflush_taken", taken, 0);
        check("rstflush_fault", fault, 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, C_ALWAYS, 16'h0000);
        check("rstflush_run", pc, 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
